expr_pipe: RTL and testbench
============================

EXPR_PIPE -- requirements
Module: expr_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 6, operand/result width per channel (2..32).
REQ-002 SHALL have parameter CHANNELS, default 3, number of parallel lanes (1..8).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream transaction valid.
REQ-006 SHALL have port in_ready  output  1  block accepts a transaction this cycle.
REQ-007 SHALL have port in_op  input  3  opcode, shared by all lanes.
REQ-008 SHALL have port in_sgn  input  1  1 = operands treated as two's-complement signed.
REQ-009 SHALL have port in_a  input  CHANNELS*WIDTH  operand A, lane k at bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port in_b  input  CHANNELS*WIDTH  operand B, same packing.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port out_y  output  CHANNELS*WIDTH  results, same packing.
REQ-014 SHALL have port out_ovf  output  CHANNELS  per-lane overflow of the presented result.
REQ-015 SHALL have port ovf_sticky  output  CHANNELS  OR of out_ovf over accepted results since clear.
REQ-016 SHALL have port clr_sticky  input  1  clears ovf_sticky.
REQ-017 SHALL have port txn_cnt  output  16  count of results accepted downstream, wraps 0xFFFF->0.

Function
REQ-018 SHALL implement a 2-stage pipeline: S1 registers op/sgn/a/b, S2 registers computed result; latency from input acceptance to out_valid = 2 cycles with no stall.
REQ-019 SHALL advance S2 when !S2.valid or out_ready; S1 when !S1.valid or S2 advances; in_ready = S1 advance condition (combinational from out_ready allowed).
REQ-020 SHALL hold out_y/out_ovf stable while out_valid=1 and out_ready=0; no transaction dropped or duplicated; full throughput of 1/cycle when out_ready=1.
REQ-021 SHALL decode op: 0 A+B; 1 A-B; 2 ~(A^B); 3 A<<B[2:0] logical; 4 A>>B[2:0] (arithmetic if sgn, else logical); 5 A>=B (signed if sgn) zero-extended; 6 A==B zero-extended; 7 B[WIDTH-1] ? A : ~A.
REQ-022 SHALL compute add/sub at WIDTH+1 bits; out_ovf=1 when true result outside WIDTH-bit range (signed range if sgn, else 0..2^WIDTH-1); all other ops out_ovf=0.
REQ-023 SHALL truncate (wrap) add/sub results to WIDTH bits unless REQ-031 applies.
REQ-024 SHALL set op 3 out_ovf=1 if any nonzero bit shifted out.
REQ-025 SHALL update ovf_sticky |= out_ovf and txn_cnt+1 on out_valid&&out_ready; clr_sticky in the same cycle wins (sticky becomes 0, that transfer's ovf not retained).

Reset
REQ-026 SHALL, with rst_n=0 at a clock edge, clear S1/S2 valid, out_valid=0, out_y=0, out_ovf=0, ovf_sticky=0, txn_cnt=0.
REQ-027 SHALL drive in_ready=0 during reset cycles and 1 in the first cycle after rst_n rises.
REQ-028 SHALL discard in-flight transactions when reset is asserted mid-operation.

Configuration
REQ-029 SHALL use macro EXPR_PIPE_SAT_EN to select saturating add/sub.
REQ-030 SHALL, without EXPR_PIPE_SAT_EN, wrap add/sub results (REQ-023).
REQ-031 SHALL, with EXPR_PIPE_SAT_EN, clamp overflowing add/sub to max/min of the active range; out_ovf still 1.

Verification (WIDTH=6, CHANNELS=3)
REQ-032 SHALL cover: op0 sgn=1 lane0 A=31 B=1 -> out_y lane0=0x20 (-32), out_ovf[0]=1; with EXPR_PIPE_SAT_EN -> 0x1F.
REQ-033 SHALL cover: op1 sgn=0 A=3 B=5 -> lane=0x3E, ovf=1; SAT_EN -> 0x00; op5 sgn=1 A=0x3F B=1 -> 0, sgn=0 -> 1.
REQ-034 SHALL cover: op4 A=0x28 B=2 -> sgn=1 0x3A, sgn=0 0x0A; op3 A=0x21 B=1 -> 0x02, ovf=1.
REQ-035 SHALL cover: 4 back-to-back inputs, out_ready=0 for 3 cycles -> in_ready drops after 2 accepted, results emerge in order, no loss.
REQ-036 SHALL cover: 0xFFFF accepted results then one more -> txn_cnt=0; clr_sticky with overflowing transfer same cycle -> ovf_sticky=0.
REQ-037 SHALL cover: rst_n low with S1,S2 full -> out_valid=0 next cycle, txn_cnt=0, prior results never emitted.

Source files
------------

// File: rtl/expr_pipe.sv
// Two-stage, multi-lane arithmetic/logic pipeline with valid/ready handshake.
// Define EXPR_PIPE_SAT_EN to clamp overflowing add/sub instead of wrapping.
module expr_pipe #(
  parameter int unsigned WIDTH    = 6,
  parameter int unsigned CHANNELS = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                in_op,
  input  logic                      in_sgn,
  input  logic [CHANNELS*WIDTH-1:0] in_a,
  input  logic [CHANNELS*WIDTH-1:0] in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_y,
  output logic [CHANNELS-1:0]       out_ovf,
  output logic [CHANNELS-1:0]       ovf_sticky,
  input  logic                      clr_sticky,
  output logic [15:0]               txn_cnt
);

  localparam int unsigned BUS_W = CHANNELS * WIDTH;
  localparam int unsigned SH_W  = (WIDTH < 3) ? WIDTH : 3;

`ifdef EXPR_PIPE_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // One lane's result: {ovf, y}
  function automatic logic [WIDTH:0] lane_eval(
    input logic [2:0]       op,
    input logic             sgn,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH:0]   ea;
    logic [WIDTH:0]   eb;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic [WIDTH+6:0] shl;
    logic [2:0]       sh;
    logic [WIDTH-1:0] smax;
    logic [WIDTH-1:0] smin;
    logic [WIDTH-1:0] y;
    logic             ovf;
    ea   = {sgn & a[WIDTH-1], a};
    eb   = {sgn & b[WIDTH-1], b};
    sum  = ea + eb;
    dif  = ea - eb;
    sh   = 3'(b[SH_W-1:0]);
    shl  = {7'd0, a} << sh;
    smax = sgn ? {1'b0, {(WIDTH-1){1'b1}}} : {WIDTH{1'b1}};
    smin = sgn ? {1'b1, {(WIDTH-1){1'b0}}} : {WIDTH{1'b0}};
    y    = '0;
    ovf  = 1'b0;
    case (op)
      3'd0: begin
        ovf = sgn ? (sum[WIDTH] ^ sum[WIDTH-1]) : sum[WIDTH];
        y   = sum[WIDTH-1:0];
        if (SAT_EN && ovf) y = (sgn && sum[WIDTH]) ? smin : smax;
      end
      3'd1: begin
        ovf = sgn ? (dif[WIDTH] ^ dif[WIDTH-1]) : dif[WIDTH];
        y   = dif[WIDTH-1:0];
        // Unsigned underflow is the only unsigned sub overflow, so it clamps low
        if (SAT_EN && ovf) y = (!sgn || dif[WIDTH]) ? smin : smax;
      end
      3'd2: y = ~(a ^ b);
      3'd3: begin
        y   = shl[WIDTH-1:0];
        ovf = |shl[WIDTH+6:WIDTH];
      end
      3'd4: y = sgn ? WIDTH'($signed(a) >>> sh) : (a >> sh);
      3'd5: y = sgn ? WIDTH'($signed(a) >= $signed(b)) : WIDTH'(a >= b);
      3'd6: y = WIDTH'(a == b);
      default: y = b[WIDTH-1] ? a : ~a;
    endcase
    return {ovf, y};
  endfunction

  logic             r_s1_valid;
  logic [2:0]       r_s1_op;
  logic             r_s1_sgn;
  logic [BUS_W-1:0] r_s1_a;
  logic [BUS_W-1:0] r_s1_b;
  logic             r_s2_valid;
  logic [BUS_W-1:0] r_s2_y;
  logic [CHANNELS-1:0] r_s2_ovf;
  logic [CHANNELS-1:0] r_sticky;
  logic [15:0]      r_cnt;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_xfer;
  logic [BUS_W-1:0] w_y;
  logic [CHANNELS-1:0] w_ovf;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign w_xfer   = r_s2_valid && out_ready;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    assign {w_ovf[k], w_y[k*WIDTH +: WIDTH]} =
      lane_eval(r_s1_op, r_s1_sgn, r_s1_a[k*WIDTH +: WIDTH], r_s1_b[k*WIDTH +: WIDTH]);
  end

  // Pipeline stages, transfer counter and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_sgn   <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_y     <= '0;
      r_s2_ovf   <= '0;
      r_sticky   <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_op  <= in_op;
          r_s1_sgn <= in_sgn;
          r_s1_a   <= in_a;
          r_s1_b   <= in_b;
        end
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        r_s2_y     <= w_y;
        r_s2_ovf   <= w_ovf;
      end
      if (clr_sticky) r_sticky <= '0;
      else if (w_xfer) r_sticky <= r_sticky | r_s2_ovf;
      if (w_xfer) r_cnt <= r_cnt + 16'd1;
    end
  end

  assign in_ready   = rst_n & w_s1_adv;
  assign out_valid  = r_s2_valid;
  assign out_y      = r_s2_y;
  assign out_ovf    = r_s2_ovf;
  assign ovf_sticky = r_sticky;
  assign txn_cnt    = r_cnt;

endmodule

// File: tb/tb_expr_pipe.sv
// Scoreboard bench for expr_pipe: integer reference model, randomized and directed traffic.
module tb_expr_pipe;

  localparam int W  = 6;
  localparam int C  = 3;
  localparam int BW = W * C;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic          in_sgn;
  logic [BW-1:0] in_a;
  logic [BW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_y;
  logic [C-1:0]  out_ovf;
  logic [C-1:0]  ovf_sticky;
  logic          clr_sticky;
  logic [15:0]   txn_cnt;

  always #5 clk = ~clk;

  expr_pipe #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_sgn(in_sgn), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_ovf(out_ovf),
    .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky), .txn_cnt(txn_cnt)
  );

  typedef struct packed {
    logic [BW-1:0] y;
    logic [C-1:0]  ovf;
  } exp_t;

  int          checks   = 0;
  int          failures = 0;
  exp_t        sb[$];
  logic        ovr_en;
  exp_t        ovr;
  logic [15:0] exp_cnt;
  logic [C-1:0] exp_sticky;
  logic        prev_stall;
  exp_t        prev_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: operands as integers, results reduced modulo 2**W
  function automatic logic [W:0] model_lane(input logic [2:0] op, input logic sgn,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
    int va, vb, t, lo, hi, sh;
    logic ovf;
    va = int'(a);
    vb = int'(b);
    if (sgn && a[W-1]) va -= 2**W;
    if (sgn && b[W-1]) vb -= 2**W;
    sh  = int'(b[2:0]);
    lo  = sgn ? -(2**(W-1)) : 0;
    hi  = sgn ? (2**(W-1) - 1) : (2**W - 1);
    ovf = 1'b0;
    t   = 0;
    case (op)
      3'd0, 3'd1: begin
        t   = (op == 3'd0) ? (va + vb) : (va - vb);
        ovf = (t < lo) || (t > hi);
`ifdef EXPR_PIPE_SAT_EN
        if (t < lo) t = lo;
        else if (t > hi) t = hi;
`endif
      end
      3'd2: t = (2**W - 1) - (int'(a) ^ int'(b));
      3'd3: begin
        t   = int'(a) * (2**sh);
        ovf = t > (2**W - 1);
      end
      3'd4: t = sgn ? (va >>> sh) : (int'(a) / (2**sh));
      3'd5: t = (va >= vb) ? 1 : 0;
      3'd6: t = (a == b) ? 1 : 0;
      default: t = b[W-1] ? int'(a) : (2**W - 1) - int'(a);
    endcase
    return {ovf, W'(t)};
  endfunction

  function automatic exp_t model(input logic [2:0] op, input logic sgn,
                                 input logic [BW-1:0] a, input logic [BW-1:0] b);
    exp_t e;
    logic [W:0] r;
    e = '0;
    for (int k = 0; k < C; k++) begin
      r = model_lane(op, sgn, a[k*W +: W], b[k*W +: W]);
      e.y[k*W +: W] = r[W-1:0];
      e.ovf[k]      = r[W];
    end
    return e;
  endfunction

  // Monitor: push on acceptance, pop and compare on output transfer
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      exp_cnt    = '0;
      exp_sticky = '0;
      prev_stall = 1'b0;
    end else begin
      check("txn_cnt", 32'(txn_cnt), 32'(exp_cnt));
      check("ovf_sticky", 32'(ovf_sticky), 32'(exp_sticky));
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_y", 32'(out_y), 32'(prev_out.y));
        check("hold_ovf", 32'(out_ovf), 32'(prev_out.ovf));
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_y, out_ovf};
      if (in_valid && in_ready)
        sb.push_back(ovr_en ? ovr : model(in_op, in_sgn, in_a, in_b));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got y=0x%0h with nothing outstanding", out_y);
        end else begin
          e = sb.pop_front();
          check("out_y", 32'(out_y), 32'(e.y));
          check("out_ovf", 32'(out_ovf), 32'(e.ovf));
          exp_cnt++;
          if (clr_sticky) exp_sticky = '0;
          else exp_sticky |= e.ovf;
        end
      end else if (clr_sticky) begin
        exp_sticky = '0;
      end
    end
  end

  // Drive one transaction and hold it until accepted; starts and ends just after a rising edge
  task automatic send(input logic [2:0] op, input logic sgn, input logic [BW-1:0] a,
                      input logic [BW-1:0] b, input logic use_ovr, input exp_t e);
    bit ok;
    in_valid = 1'b1; in_op = op; in_sgn = sgn; in_a = a; in_b = b;
    ovr_en = use_ovr; ovr = e;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    ovr_en   = 1'b0;
  endtask

  task automatic dir(input logic [2:0] op, input logic sgn, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] y, input logic ovf);
    exp_t e;
    e.y   = {C{y}};
    e.ovf = {C{ovf}};
    send(op, sgn, {C{a}}, {C{b}}, 1'b1, e);
  endtask

  function automatic logic [W-1:0] rand_opnd();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = {W{1'b1}};
      2: v = {1'b0, {(W-1){1'b1}}};
      3: v = {1'b1, {(W-1){1'b0}}};
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  function automatic logic [BW-1:0] rand_bus();
    logic [BW-1:0] v;
    for (int k = 0; k < C; k++) v[k*W +: W] = rand_opnd();
    return v;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t none;
    none = '0;
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_sgn = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b0; clr_sticky = 1'b0; ovr_en = 1'b0; ovr = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_y", 32'(out_y), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    check("rst_sticky", 32'(ovf_sticky), 32'd0);
    check("rst_txn_cnt", 32'(txn_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed corner vectors with constant expectations
    out_ready = 1'b1;
`ifdef EXPR_PIPE_SAT_EN
    dir(3'd0, 1'b1, 6'd31, 6'd1, 6'h1F, 1'b1);
    dir(3'd1, 1'b0, 6'd3,  6'd5, 6'h00, 1'b1);
`else
    dir(3'd0, 1'b1, 6'd31, 6'd1, 6'h20, 1'b1);
    dir(3'd1, 1'b0, 6'd3,  6'd5, 6'h3E, 1'b1);
`endif
    dir(3'd5, 1'b1, 6'h3F, 6'd1, 6'h00, 1'b0);
    dir(3'd5, 1'b0, 6'h3F, 6'd1, 6'h01, 1'b0);
    dir(3'd4, 1'b1, 6'h28, 6'd2, 6'h3A, 1'b0);
    dir(3'd4, 1'b0, 6'h28, 6'd2, 6'h0A, 1'b0);
    dir(3'd3, 1'b0, 6'h21, 6'd1, 6'h02, 1'b1);
    dir(3'd2, 1'b0, 6'h15, 6'h0F, 6'h25, 1'b0);
    dir(3'd7, 1'b0, 6'h15, 6'h20, 6'h15, 1'b0);
    dir(3'd7, 1'b0, 6'h15, 6'h1F, 6'h2A, 1'b0);
    idle(5);
    check("sticky_after_ovf", 32'(ovf_sticky), 32'h7);
    check("cnt_directed", 32'(txn_cnt), 32'd10);

    // Backpressure: out_ready low for three cycles with back-to-back inputs
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd0; in_sgn = 1'b0; in_a = rand_bus(); in_b = rand_bus();
    @(negedge clk); check("bp_acc0", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_a = rand_bus(); in_b = rand_bus(); in_op = 3'd1;
    @(negedge clk); check("bp_acc1", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_a = rand_bus(); in_b = rand_bus(); in_op = 3'd2;
    @(negedge clk);
    check("bp_stall_ready", 32'(in_ready), 32'd0);
    check("bp_stall_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(in_op, in_sgn, in_a, in_b, 1'b0, none);
    send(3'd4, 1'b1, rand_bus(), rand_bus(), 1'b0, none);
    idle(5);
    check("bp_drain", sb.size(), 32'd0);

    // Sticky clear alone, then clear coinciding with an overflowing transfer
    clr_sticky = 1'b1;
    idle(1);
    clr_sticky = 1'b0;
    @(negedge clk); check("clr_alone", 32'(ovf_sticky), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(3'd0, 1'b1, {C{6'd31}}, {C{6'd1}}, 1'b0, none);
    wait_out_valid();
    @(posedge clk); #1;
    out_ready = 1'b1; clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    @(negedge clk); check("clr_wins", 32'(ovf_sticky), 32'd0);
    @(posedge clk); #1;

    // Reset with both stages full: nothing in flight may emerge
    out_ready = 1'b0;
    send(3'd0, 1'b0, rand_bus(), rand_bus(), 1'b0, none);
    send(3'd1, 1'b0, rand_bus(), rand_bus(), 1'b0, none);
    @(negedge clk); check("full_before_rst", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_flush_valid", 32'(out_valid), 32'd0);
    check("rst_flush_cnt", 32'(txn_cnt), 32'd0);
    check("rst_flush_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    idle(8);
    check("no_stale_out", 32'(txn_cnt), 32'd0);

    // Randomized traffic with random backpressure and sticky clears
    for (int i = 0; i < 1500; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_op      = 3'($urandom_range(0, 7));
      in_sgn     = 1'($urandom);
      in_a       = rand_bus();
      in_b       = rand_bus();
      out_ready  = ($urandom_range(0, 9) < 7);
      clr_sticky = ($urandom_range(0, 24) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; clr_sticky = 1'b0; out_ready = 1'b1;
    idle(6);
    check("rand_drain", sb.size(), 32'd0);

    // Counter wrap: 0xFFFF transfers, then one more
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      in_op  = 3'($urandom_range(0, 7));
      in_sgn = 1'($urandom);
      in_a   = BW'($urandom);
      in_b   = BW'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    idle(5);
    check("cnt_ffff", 32'(txn_cnt), 32'h0000FFFF);
    send(3'd6, 1'b0, rand_bus(), rand_bus(), 1'b0, none);
    idle(5);
    check("cnt_wrap", 32'(txn_cnt), 32'd0);
    check("final_drain", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
